// File: rtl/tone_pkg.sv
// Shared states, channel sizing and LED bit positions for the tone scan controller.
package tone_pkg;

    localparam int unsigned NUM_CH        = 5;
    localparam int unsigned CH_W          = 3;
    localparam int unsigned LED_W         = 8;
    localparam int unsigned LED_STICKY_HI = 7;
    localparam int unsigned LED_STICKY_LO = 3;
    localparam int unsigned LED_QUAL      = 2;
    localparam int unsigned LED_REL       = 1;
    localparam int unsigned LED_DONE      = 0;

    typedef enum logic [1:0] {
        SCAN,
        QUALIFY,
        DETECTED,
        RELEASE
    } tone_state_e;

    // Successor channel index, wrapping the last channel back to 0.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == CH_W'(NUM_CH - 1)) ? '0 : c + CH_W'(1);
    endfunction

endpackage

// File: rtl/tone_rr_picker.sv
// Rotating-priority encoder: first set req bit searching upward from ptr, wrapping.
module tone_rr_picker
    import tone_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    int unsigned pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pos = (32'(ptr) + i) % NUM_CH;
            if (!found && req[CH_W'(pos)]) begin
                found = 1'b1;
                idx   = CH_W'(pos);
            end
        end
    end

endmodule

// File: rtl/tone_scan_controller.sv
// Round-robin tone qualifier sharing one counter across the band-pass channels.
// Optional low-glitch tolerance in QUALIFY: define TONE_GLITCH_FILTER_EN.
module tone_scan_controller
    import tone_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 25_000_000,
    parameter int unsigned RELEASE_CYCLES = 1000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] bp,
    input  logic              clear,
    output logic [LED_W-1:0]  led,
    output logic              detect_pulse,
    output logic [CH_W-1:0]   detect_id,
    output logic              all_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

    logic [NUM_CH-1:0] sync_q, sbp;
    tone_state_e       state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, rr_ptr_q, rr_ptr_d, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [LED_W-1:0]  led_d;
    logic              pulse_d;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;

`ifdef TONE_GLITCH_FILTER_EN
    localparam int unsigned GLITCH_CYCLES = 16;
    localparam int unsigned GLITCH_W      = 5;
    localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES);
    logic [GLITCH_W-1:0] gcnt_q, gcnt_d;
`endif

    // Sticky channels are masked so a tone that stays on cannot starve the others.
    tone_rr_picker u_picker (
        .req   (sbp & ~sticky_q),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = detect_id;
        pulse_d  = 1'b0;
        sticky_d = clear ? '0 : sticky_q;
`ifdef TONE_GLITCH_FILTER_EN
        gcnt_d   = gcnt_q;
`endif
        case (state_q)
            SCAN: begin
                if (pick_found) begin
                    ch_d    = pick_idx;
                    cnt_d   = '0;
                    state_d = QUALIFY;
`ifdef TONE_GLITCH_FILTER_EN
                    gcnt_d  = '0;
`endif
                end
            end
            QUALIFY: begin
                if (sbp[ch_q]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == HOLD_LAST) state_d = DETECTED;
`ifdef TONE_GLITCH_FILTER_EN
                    gcnt_d = '0;
                end else if (gcnt_q != GLITCH_LAST) begin
                    gcnt_d = gcnt_q + GLITCH_W'(1);
`endif
                end else begin
                    rr_ptr_d = next_ch(ch_q);
                    state_d  = SCAN;
                end
            end
            DETECTED: begin
                // Setting the flag after the clear lets set win for this channel.
                sticky_d[ch_q] = 1'b1;
                pulse_d        = 1'b1;
                id_d           = ch_q;
                cnt_d          = '0;
                state_d        = RELEASE;
            end
            RELEASE: begin
                if (sbp[ch_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == REL_LAST) begin
                    rr_ptr_d = next_ch(ch_q);
                    state_d  = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SCAN;
        endcase

        // LED image registered from next-state values so it tracks the FSM without lag.
        led_d = '0;
        led_d[LED_STICKY_HI:LED_STICKY_LO] =
            {sticky_d[0], sticky_d[1], sticky_d[2], sticky_d[3], sticky_d[4]};
        led_d[LED_QUAL] = (state_d == QUALIFY);
        led_d[LED_REL]  = (state_d == RELEASE);
        led_d[LED_DONE] = &sticky_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q       <= '0;
            sbp          <= '0;
            state_q      <= SCAN;
            ch_q         <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            sticky_q     <= '0;
            led          <= '0;
            detect_pulse <= 1'b0;
            detect_id    <= '0;
            all_done     <= 1'b0;
            busy         <= 1'b0;
`ifdef TONE_GLITCH_FILTER_EN
            gcnt_q       <= '0;
`endif
        end else begin
            sync_q       <= bp;
            sbp          <= sync_q;
            state_q      <= state_d;
            ch_q         <= ch_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            sticky_q     <= sticky_d;
            led          <= led_d;
            detect_pulse <= pulse_d;
            detect_id    <= id_d;
            all_done     <= &sticky_d;
            busy         <= (state_d != SCAN);
`ifdef TONE_GLITCH_FILTER_EN
            gcnt_q       <= gcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tone_scan_controller.sv
// Directed self-checking bench for tone_scan_controller (HOLD=16, RELEASE=4).
module tb_tone_scan_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] bp;
    logic       clear;
    logic [7:0] led;
    logic       detect_pulse;
    logic [2:0] detect_id;
    logic       all_done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    tone_scan_controller #(
        .HOLD_CYCLES    (16),
        .RELEASE_CYCLES (4),
        .CNT_W          (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bp           (bp),
        .clear        (clear),
        .led          (led),
        .detect_pulse (detect_pulse),
        .detect_id    (detect_id),
        .all_done     (all_done),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        bp    = '0;
        clear = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick(1);
            n++;
            if (detect_pulse) break;
        end
    endtask

    task automatic wait_led(input logic [2:0] bit_idx, input logic val, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (led[bit_idx] === val) break;
            tick(1);
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) break;
            tick(1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bp    = '0;
        clear = 1'b0;
        tick(3);
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL rst_led: got %h expected 00", led); end
        checks++; if (detect_pulse !== 1'b0) begin failures++; $display("FAIL rst_pulse: got %b expected 0", detect_pulse); end
        checks++; if (detect_id !== 3'd0) begin failures++; $display("FAIL rst_id: got %0d expected 0", detect_id); end
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL rst_all_done: got %b expected 0", all_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_single_channel;
        int n;
        apply_reset;
        bp = 5'b00001;
        wait_pulse(100, n);
        checks++; if (n !== 20) begin failures++; $display("FAIL t1_latency: got %0d expected 20", n); end
        checks++; if (detect_id !== 3'd0) begin failures++; $display("FAIL t1_id: got %0d expected 0", detect_id); end
        checks++; if (led !== 8'b1000_0010) begin failures++; $display("FAIL t1_led_release: got %b expected 10000010", led); end
        tick(1);
        checks++; if (detect_pulse !== 1'b0) begin failures++; $display("FAIL t1_pulse_width: got %b expected 0", detect_pulse); end
        bp = '0;
        tick(5);
        checks++; if (led[1] !== 1'b1) begin failures++; $display("FAIL t1_release_hold: got %b expected 1", led[1]); end
        tick(1);
        checks++; if (led !== 8'b1000_0000) begin failures++; $display("FAIL t1_release_done: got %b expected 10000000", led); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_idle: got %b expected 0", busy); end
    endtask

    task automatic test_abort_retry;
        logic       seen;
        logic [2:0] id;
        apply_reset;
        seen = 1'b0;
        id   = 3'd7;
        bp   = 5'b00100;
        for (int i = 0; i < 10; i++) begin tick(1); if (detect_pulse) seen = 1'b1; end
        bp = '0;
        for (int i = 0; i < 10; i++) begin tick(1); if (detect_pulse) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t2_abort_no_pulse: got %b expected 0", seen); end
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL t2_abort_sticky: got %b expected 00000000", led); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_abort_scan: got %b expected 0", busy); end
        bp = 5'b00100;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (detect_pulse) begin seen = 1'b1; id = detect_id; end
        end
        bp = '0;
        tick(10);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL t2_retry_pulse: got %b expected 1", seen); end
        checks++; if (id !== 3'd2) begin failures++; $display("FAIL t2_retry_id: got %0d expected 2", id); end
        checks++; if (led !== 8'b0010_0000) begin failures++; $display("FAIL t2_retry_led: got %b expected 00100000", led); end
    endtask

    task automatic test_ptr_after_abort;
        int n;
        apply_reset;
        bp = 5'b00100;
        tick(10);
        bp = '0;
        tick(6);
        bp = 5'b10100;
        wait_pulse(100, n);
        checks++; if (detect_pulse !== 1'b1) begin failures++; $display("FAIL t2b_pulse: got %b expected 1", detect_pulse); end
        checks++; if (detect_id !== 3'd4) begin failures++; $display("FAIL t2b_rr_order: got %0d expected 4", detect_id); end
    endtask

    task automatic test_all_channels;
        int   n;
        logic seen;
        apply_reset;
        bp = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(200, n);
            checks++; if (detect_id !== 3'(k) || detect_pulse !== 1'b1) begin
                failures++; $display("FAIL t3_order_%0d: got id %0d pulse %b expected id %0d pulse 1", k, detect_id, detect_pulse, k);
            end
            bp[3'(k)] = 1'b0;
            if (k > 0) bp[3'(k - 1)] = 1'b1;
        end
        tick(1);
        wait_idle(50);
        checks++; if (led !== 8'b1111_1001) begin failures++; $display("FAIL t3_led_all: got %b expected 11111001", led); end
        checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL t3_all_done: got %b expected 1", all_done); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(1); if (detect_pulse || busy) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t3_sticky_mask: got %b expected 0", seen); end
    endtask

    task automatic test_clear;
        int n;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (led[7:3] !== 5'b00000) begin failures++; $display("FAIL t4_clear_led: got %b expected 00000", led[7:3]); end
        checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL t4_clear_done: got %b expected 0", all_done); end
        apply_reset;
        bp = 5'b00001;
        wait_pulse(100, n);
        bp = '0;
        tick(1);
        wait_idle(50);
        checks++; if (led !== 8'b1000_0000) begin failures++; $display("FAIL t4_pre_sticky: got %b expected 10000000", led); end
        bp = 5'b01000;
        wait_led(3'd2, 1'b1, 60);
        wait_led(3'd2, 1'b0, 60);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t4_in_detected: got %b expected 1", busy); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (detect_pulse !== 1'b1) begin failures++; $display("FAIL t4_set_pulse: got %b expected 1", detect_pulse); end
        checks++; if (detect_id !== 3'd3) begin failures++; $display("FAIL t4_set_id: got %0d expected 3", detect_id); end
        checks++; if (led[7:3] !== 5'b00010) begin failures++; $display("FAIL t4_set_wins: got %b expected 00010", led[7:3]); end
        bp = '0;
    endtask

    task automatic test_reset_mid_qualify;
        int   n;
        logic seen;
        apply_reset;
        bp = 5'b00001;
        wait_led(3'd2, 1'b1, 60);
        tick(8);
        reset = 1'b1;
        tick(1);
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL t5_led: got %b expected 00000000", led); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_busy: got %b expected 0", busy); end
        checks++; if (detect_id !== 3'd0 || all_done !== 1'b0) begin
            failures++; $display("FAIL t5_outputs: got id %0d done %b expected id 0 done 0", detect_id, all_done);
        end
        seen = detect_pulse;
        for (int i = 0; i < 3; i++) begin tick(1); if (detect_pulse) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t5_no_pulse: got %b expected 0", seen); end
        reset = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_resume_scan: got %b expected 0", busy); end
        wait_pulse(100, n);
        checks++; if (n !== 19 || detect_id !== 3'd0) begin
            failures++; $display("FAIL t5_requalify: got %0d cycles id %0d expected 19 cycles id 0", n, detect_id);
        end
        bp = '0;
    endtask

    task automatic run_gap(input int len, output logic aborted, output logic detected);
        apply_reset;
        bp = 5'b00010;
        wait_led(3'd2, 1'b1, 60);
        tick(4);
        bp = '0;
        tick(len);
        bp = 5'b00010;
        aborted  = 1'b0;
        detected = 1'b0;
        for (int i = 0; i < 120 && !detected; i++) begin
            tick(1);
            if (detect_pulse) detected = 1'b1;
            else if (!busy) aborted = 1'b1;
        end
        bp = '0;
    endtask

    task automatic test_glitch;
        logic ab;
        logic det;
`ifdef TONE_GLITCH_FILTER_EN
        run_gap(16, ab, det);
        checks++; if (ab !== 1'b0) begin failures++; $display("FAIL t6_gap16_abort: got %b expected 0", ab); end
        checks++; if (det !== 1'b1) begin failures++; $display("FAIL t6_gap16_detect: got %b expected 1", det); end
        run_gap(17, ab, det);
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL t6_gap17_abort: got %b expected 1", ab); end
        checks++; if (det !== 1'b1) begin failures++; $display("FAIL t6_gap17_redetect: got %b expected 1", det); end
`else
        run_gap(1, ab, det);
        checks++; if (ab !== 1'b1) begin failures++; $display("FAIL t6_gap1_abort: got %b expected 1", ab); end
        checks++; if (det !== 1'b1) begin failures++; $display("FAIL t6_gap1_redetect: got %b expected 1", det); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        bp    = '0;
        clear = 1'b0;
        test_reset;
        test_single_channel;
        test_abort_retry;
        test_ptr_after_abort;
        test_all_channels;
        test_clear;
        test_reset_mid_qualify;
        test_glitch;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
